// File: rtl/alu_pkg.sv
// Shared ALU definitions: gout control codes (common with the ALU control
// decoder), the execution FSM state encoding and a small code classifier.
package alu_pkg;

    localparam int unsigned GOUT_W = 3;

    // ALU control codes driven by the ALU control decoder
    localparam logic [GOUT_W-1:0] ALU_AND  = 3'b000;
    localparam logic [GOUT_W-1:0] ALU_OR   = 3'b001;
    localparam logic [GOUT_W-1:0] ALU_ADD  = 3'b010;
    localparam logic [GOUT_W-1:0] ALU_RSVD = 3'b011;
    localparam logic [GOUT_W-1:0] ALU_SLL  = 3'b100;
    localparam logic [GOUT_W-1:0] ALU_SRL  = 3'b101;
    localparam logic [GOUT_W-1:0] ALU_SUB  = 3'b110;
    localparam logic [GOUT_W-1:0] ALU_NOR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for the two codes executed by the iterative shifter
    function automatic logic is_shift(input logic [GOUT_W-1:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_seq_exec_comb_core.sv
// alu_comb_core: single-cycle combinational ALU for AND/OR/ADD/SUB/NOR.
// Reserved and shift codes give 0 (shifts are handled by the sequencer).
// Ports:
//   i_gout      ALU control code
//   i_a, i_b    operands
//   o_result_c  combinational result
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [GOUT_W-1:0] i_gout,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    output logic [WIDTH-1:0]  o_result_c
);

    // Add/sub wrap modulo 2^WIDTH; carry and overflow are not kept
    always_comb begin
        o_result_c = '0;
        case (i_gout)
            ALU_AND: o_result_c = i_a & i_b;
            ALU_OR:  o_result_c = i_a | i_b;
            ALU_ADD: o_result_c = i_a + i_b;
            ALU_SUB: o_result_c = i_a - i_b;
            ALU_NOR: o_result_c = ~(i_a | i_b);
            default: o_result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execution-side consumer of the ALU control code. Takes one
// operation per valid/ready handshake; logic/arith ops finish in one cycle,
// SLL/SRL shift one bit position per cycle.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   operation handshake (gout, a, b, shamt)
//   out_valid / out_ready result handshake (result, zero)
//   busy                  high whenever the FSM is not idle
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        gout,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [SHW-1:0]    shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              busy
);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic [WIDTH-1:0]   r_acc;
    logic [SHW-1:0]     r_cnt;
    logic               r_is_sll;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_comb_result;
    logic [WIDTH-1:0]   w_acc_shift;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [SHW-1:0]     w_cnt_nxt;
    logic               w_is_sll_nxt;
    logic               w_res_load;
    logic [WIDTH-1:0]   w_res_nxt;

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_comb_core (
        .i_gout     (gout),
        .i_a        (a),
        .i_b        (b),
        .o_result_c (w_comb_result)
    );

    // One-bit step of the iterative shifter, zero fill in both directions
    assign w_acc_shift = r_is_sll ? {r_acc[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_acc[WIDTH-1:1]};

    // Next-state and datapath control
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_is_sll_nxt = r_is_sll;
        w_res_load   = 1'b0;
        w_res_nxt    = r_result;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift(gout) && (shamt != '0)) begin
                        w_acc_nxt    = b;
                        w_cnt_nxt    = shamt;
                        w_is_sll_nxt = (gout == ALU_SLL);
                        w_state_nxt  = ST_SHIFT;
                    end else begin
                        // shift by zero passes b through unchanged
                        w_res_load  = 1'b1;
                        w_res_nxt   = is_shift(gout) ? b : w_comb_result;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                w_acc_nxt = w_acc_shift;
                w_cnt_nxt = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_res_load  = 1'b1;
                    w_res_nxt   = w_acc_shift;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; handshake/status outputs are decoded from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Shifter, counter and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_sll <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_sll <= w_is_sll_nxt;
            if (w_res_load) begin
                r_result <= w_res_nxt;
                r_zero   <= (w_res_nxt == '0);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed plan items followed by
// random operations compared against an arithmetic reference model.
module tb_alu_seq_exec;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       gout;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq_exec #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gout      (gout),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: result straight from the operation definitions
    function automatic logic [31:0] ref_result(input logic [2:0] g, input logic [31:0] x,
                                               input logic [31:0] y, input logic [4:0] s);
        case (g)
            3'b010:  return x + y;
            3'b110:  return x - y;
            3'b001:  return x | y;
            3'b000:  return x & y;
            3'b100:  return y << s;
            3'b101:  return y >> s;
            3'b111:  return ~(x | y);
            default: return 32'd0;
        endcase
    endfunction

    // Reference: cycles from accept edge until out_valid is seen
    function automatic int ref_latency(input logic [2:0] g, input logic [4:0] s);
        if ((g == 3'b100 || g == 3'b101) && s != 5'd0) return int'(s) + 1;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        gout = 3'b000; a = '0; b = '0; shamt = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
    endtask

    // Issue one op; hold out_ready low for 'delay' cycles after out_valid
    // (delay 0 means out_ready is already high before the result appears).
    task automatic run_op(input string tag, input logic [2:0] g, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] s, input int delay);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        exp_res = ref_result(g, x, y, s);
        exp_lat = ref_latency(g, s);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; gout = g; a = x; b = y; shamt = s;
        out_ready = (delay == 0);
        @(posedge clk);
        lat = 0;
        // keep offering garbage while busy: must be ignored and not disturb the op
        do begin
            @(negedge clk);
            lat++;
            gout = 3'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
            if (lat == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (!out_valid) check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        end while (!out_valid && lat < 100);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, 32'(zero), 32'(exp_res == 32'd0));
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            gout = 3'($urandom); a = $urandom; b = $urandom;
            check({tag, "_hold_result"}, result, exp_res);
            check({tag, "_hold_valid"}, 32'({out_valid, in_ready}), 32'b10);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_post_hs"}, 32'({out_valid, in_ready, busy}), 32'b010);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        gout = '0; a = '0; b = '0; shamt = '0;
        do_reset();

        // Directed plan items
        run_op("add", 3'b010, 32'd5, 32'd7, 5'd0, 0);
        run_op("sub_zero", 3'b110, 32'd9, 32'd9, 5'd0, 0);
        run_op("sub_wrap", 3'b110, 32'd0, 32'd1, 5'd0, 0);
        run_op("sll4", 3'b100, 32'd0, 32'h0000_0003, 5'd4, 0);
        run_op("srl31", 3'b101, 32'd0, 32'h8000_0000, 5'd31, 0);
        run_op("sll31_one", 3'b100, 32'd0, 32'h0000_0001, 5'd31, 1);
        run_op("nor_bp", 3'b111, 32'd0, 32'd0, 5'd0, 5);
        run_op("rsvd", 3'b011, 32'hFFFF_FFFF, 32'h1234_5678, 5'd0, 0);
        run_op("srl0", 3'b101, 32'd0, 32'h0000_1234, 5'd0, 2);

        // Reset in the third SHIFT cycle of SLL by 10
        @(negedge clk);
        in_valid = 1'b1; gout = 3'b100; a = '0; b = 32'h0000_00FF; shamt = 5'd10;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midrst_state", 32'({out_valid, in_ready, busy}), 32'b010);
        check("midrst_result", result, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("midrst_no_stale", 32'(seen), 32'd0);
        end
        out_ready = 1'b0;

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [2:0] g;
            logic [4:0] s;
            g = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       s = 5'd0;
                1:       s = 5'd31;
                default: s = 5'($urandom);
            endcase
            run_op("rand", g, $urandom, $urandom, s, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
